// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer shared definitions: instruction codes, FSM states,
// flag bit positions and the instruction decoder.
package exec_sequencer_pkg;

    localparam logic [3:0] OPC_REG  = 4'b0000;
    localparam logic [3:0] CODE_AND = 4'b0001;
    localparam logic [3:0] CODE_OR  = 4'b0010;
    localparam logic [3:0] CODE_XOR = 4'b0011;
    localparam logic [3:0] CODE_ADD = 4'b0101;
    localparam logic [3:0] CODE_SUB = 4'b1001;
    localparam logic [3:0] CODE_CMP = 4'b1011;
    localparam logic [3:0] CODE_MOV = 4'b1101;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE
    } state_t;

    typedef enum logic [2:0] {
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_ADD,
        OP_SUB,
        OP_CMP,
        OP_MOV,
        OP_ILL
    } alu_op_t;

    typedef struct packed {
        alu_op_t op;
        logic    imm;
        logic    sx;
    } dec_t;

    // Immediate forms reuse the ext code as their opcode.
    function automatic dec_t decode(input logic [15:0] ins);
        dec_t       d;
        logic [3:0] code;
        d.imm = (ins[15:12] != OPC_REG);
        code  = d.imm ? ins[15:12] : ins[7:4];
        unique case (1'b1)
            code == CODE_AND: d.op = OP_AND;
            code == CODE_OR:  d.op = OP_OR;
            code == CODE_XOR: d.op = OP_XOR;
            code == CODE_ADD: d.op = OP_ADD;
            code == CODE_SUB: d.op = OP_SUB;
            code == CODE_CMP: d.op = OP_CMP;
            code == CODE_MOV: d.op = OP_MOV;
            default:          d.op = OP_ILL;
        endcase
        d.sx = d.imm && (d.op inside {OP_ADD, OP_SUB, OP_CMP});
        return d;
    endfunction

    function automatic logic [15:0] ext_imm(input logic [7:0] imm,
                                            input logic       sx);
        return sx ? {{8{imm[7]}}, imm} : {8'h00, imm};
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Upstream instruction handshake plus register-file port bundle.
interface exec_sequencer_if;

    logic        InstrValid;
    logic [15:0] Instr;
    logic        InstrReady;
    logic [3:0]  RdestRegLoc;
    logic [3:0]  RsrcRegLoc;
    logic [15:0] RdestIn;
    logic [15:0] RsrcIn;
    logic        WrEn;
    logic [15:0] Load;
    logic [4:0]  Flags;
    logic        Done;
    logic        Illegal;

    modport master (
        input  InstrValid, Instr, RdestIn, RsrcIn,
        output InstrReady, RdestRegLoc, RsrcRegLoc,
        output WrEn, Load, Flags, Done, Illegal
    );

    modport slave (
        output InstrValid, Instr, RdestIn, RsrcIn,
        input  InstrReady, RdestRegLoc, RsrcRegLoc,
        input  WrEn, Load, Flags, Done, Illegal
    );

endinterface

// File: rtl/exec_sequencer_alu.sv
// exec_alu: combinational result, next-flags and write-enable
// for one decoded operation.
module exec_alu
    import exec_sequencer_pkg::*;
(
    input  alu_op_t     op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [4:0]  flags_in,
    output logic [15:0] result,
    output logic [4:0]  flags_out,
    output logic        wr
);

    logic [16:0] sum;
    logic [15:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a - b;

    always_comb begin
        result    = '0;
        flags_out = flags_in;
        wr        = 1'b1;
        unique case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ADD: begin
                result            = sum[15:0];
                flags_out[FLAG_C] = sum[16];
                flags_out[FLAG_F] = (a[15] == b[15]) &&
                                    (sum[15] != a[15]);
            end
            OP_SUB: begin
                result            = diff;
                flags_out[FLAG_C] = a < b;
                flags_out[FLAG_F] = (a[15] != b[15]) &&
                                    (diff[15] != a[15]);
            end
            OP_CMP: begin
                result            = diff;
                wr                = 1'b0;
                flags_out[FLAG_Z] = a == b;
                flags_out[FLAG_L] = a < b;
                flags_out[FLAG_N] = $signed(a) < $signed(b);
            end
            OP_MOV: result = b;
            default: wr = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: four-state IDLE/READ/EXEC/WRITE instruction
// sequencer around an external register file and exec_alu.
module exec_sequencer
    import exec_sequencer_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    exec_sequencer_if.master bus
);

    state_t      state, state_nx;
    logic [15:0] ir, op_a, op_b, res;
    logic [4:0]  flags;
    logic        wr_en, done, ill;
    dec_t        dec;
    logic [15:0] alu_res;
    logic [4:0]  alu_flags;
    logic        alu_wr;

    assign dec = decode(ir);

    exec_alu u_alu (
        .op        (dec.op),
        .a         (op_a),
        .b         (op_b),
        .flags_in  (flags),
        .result    (alu_res),
        .flags_out (alu_flags),
        .wr        (alu_wr)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (bus.InstrValid) state_nx = S_READ;
            S_READ:  state_nx = S_EXEC;
            S_EXEC:  state_nx = S_WRITE;
            S_WRITE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ir    <= '0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            flags <= '0;
            wr_en <= 1'b0;
            done  <= 1'b0;
            ill   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.InstrValid) ir <= bus.Instr;
                S_READ: begin
                    op_a <= bus.RdestIn;
                    op_b <= dec.imm ? ext_imm(ir[7:0], dec.sx)
                                    : bus.RsrcIn;
                end
                // Status outputs register here so they cover WRITE exactly.
                S_EXEC: begin
                    res   <= alu_res;
                    flags <= alu_flags;
                    wr_en <= alu_wr;
                    done  <= 1'b1;
                    ill   <= (dec.op == OP_ILL);
                end
                S_WRITE: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    ill   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.InstrReady  = (state == S_IDLE);
    assign bus.RdestRegLoc = ir[11:8];
    assign bus.RsrcRegLoc  = ir[3:0];
    assign bus.WrEn        = wr_en;
    assign bus.Load        = res;
    assign bus.Flags       = flags;
    assign bus.Done        = done;
    assign bus.Illegal     = ill;

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst  input  1  asynchronous, active-low reset.
REQ-003 InstrValid  input  1  upstream asserts when Instr is valid.
REQ-004 Instr  input  16  instruction: [15:12] opcode, [11:8] Rdest, [7:4] ext, [3:0] Rsrc; imm = [7:0].
REQ-005 InstrReady  output  1  high only in IDLE; transfer occurs on the rising edge where InstrValid&InstrReady.
REQ-006 RdestRegLoc  output  4  register-file Rdest read/write address.
REQ-007 RsrcRegLoc  output  4  register-file Rsrc read address.
REQ-008 RdestIn  input  16  register-file Rdest read data (combinational read).
REQ-009 RsrcIn  input  16  register-file Rsrc read data (combinational read).
REQ-010 WrEn  output  1  register-file write enable, drives En.
REQ-011 Load  output  16  register-file write data.
REQ-012 Flags  output  5  {N,Z,F,L,C}, bit 4 down to bit 0.
REQ-013 Done  output  1  one-cycle pulse at completion of every accepted instruction.
REQ-014 Illegal  output  1  one-cycle pulse, coincident with Done, for an undecoded instruction.

Function
REQ-015 FSM states SHALL be IDLE, READ, EXEC, WRITE; transitions IDLE->READ on transfer, READ->EXEC, EXEC->WRITE, WRITE->IDLE unconditionally.
REQ-016 On transfer, Instr SHALL be latched; RdestRegLoc/RsrcRegLoc SHALL come from the latch and stay stable from READ through WRITE.
REQ-017 In READ, RdestIn -> operand A and RsrcIn -> register operand B SHALL be captured.
REQ-018 In EXEC, result and next-flag values SHALL be computed from A and B and registered.
REQ-019 In WRITE, Load SHALL equal the result, and WrEn SHALL be 1 for writing ops and 0 for CMP/CMPI/illegal; Done=1.
REQ-020 Latency: transfer at edge t0 -> WrEn high in the cycle after edge t2 -> register file captures at edge t3; throughput is one instruction per 4 cycles.
REQ-021 Register ops (opcode 0000), keyed by ext: AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101.
REQ-022 Immediate ops SHALL use opcode equal to the matching ext code; ADDI/SUBI/CMPI sign-extend imm[7:0]; ANDI/ORI/XORI/MOVI zero-extend.
REQ-023 Any other opcode/ext combination SHALL be illegal: no write, flags unchanged, Illegal pulsed.
REQ-024 Arithmetic is 16-bit modulo 2^16; ADD: C=carry out of bit 15, F=signed overflow; SUB: C=borrow (A<B unsigned), F=signed overflow.
REQ-025 CMP/CMPI: Z=(A==B), L=(A<B unsigned), N=(A<B signed); C and F unchanged.
REQ-026 ADD/SUB SHALL leave Z,L,N unchanged; logic ops and MOV SHALL leave all flags unchanged.
REQ-027 Flags SHALL update at the EXEC->WRITE edge only.
REQ-028 InstrValid outside IDLE SHALL be ignored; the upstream block holds Instr until the transfer.
REQ-029 Rdest==Rsrc SHALL be legal; operands are the pre-write value.

Reset
REQ-030 Rst low SHALL asynchronously force IDLE, WrEn=0, Done=0, Illegal=0, Flags=0, the latched instruction=0, and A, B, and the result=0.
REQ-031 Reset mid-operation SHALL abandon the instruction with no register-file write.
REQ-032 After Rst deasserts, InstrReady SHALL be 1 in the first cycle.

Structure
REQ-033 The shared package SHALL hold the opcode/ext constants, the state encoding, and the flag bit indices.
REQ-034 A single combinational sub-module, exec_alu, SHALL compute the result and the next flags from (op, A, B, flags_in).

Verification
REQ-035 Verify ADD: r1=0x7FFF, r2=0x0001 -> Load=0x8000 and WrEn at t0+3; C=0, F=1.
REQ-036 Verify SUBI: r3=0x0000, imm=0x01 -> Load=0xFFFF, C=1, F=0.
REQ-037 Verify CMP: r4=0x8000, r5=0x0001 -> WrEn=0, Z=0, L=0, N=1, Done pulses once.
REQ-038 Verify ANDI zero-extension: r6=0xFFFF, imm=0xF0 -> Load=0x00F0, flags unchanged.
REQ-039 Verify illegal instruction 0xF000 -> Illegal=Done=1 for one cycle, WrEn=0; InstrValid held in EXEC is ignored.
REQ-040 Verify reset: Rst low during EXEC -> WrEn never asserts, Flags=0, InstrReady=1 after release.
